// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, sequencer states and datapath width.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_PASS_A = 2'b10;
    localparam logic [1:0] OP_PASS_B = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 4-bit ALU; ADD/SUB wrap modulo 2^ALU_W with no carry/borrow out.
module alu_share_arbiter_alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [1:0]       opcode,
    output logic [ALU_W-1:0] result
);

    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:    result = a + b;
            OP_SUB:    result = a - b;
            OP_PASS_A: result = a;
            OP_PASS_B: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU among N requesters:
// grant in IDLE, compute in EXEC, hold the result in RESP until accepted.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = ALU_W,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      io_req_valid,
    output logic [N-1:0]      io_req_ready,
    input  logic [N*W-1:0]    io_req_a,
    input  logic [N*W-1:0]    io_req_b,
    input  logic [N*2-1:0]    io_req_opcode,
    output logic              io_resp_valid,
    input  logic              io_resp_ready,
    output logic [W-1:0]      io_resp_data,
    output logic [ID_W-1:0]   io_resp_id,
    output logic              io_busy,
    output logic [7:0]        io_ops_done
);

    logic [W-1:0] a_arr  [N];
    logic [W-1:0] b_arr  [N];
    logic [1:0]   op_arr [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi]  = io_req_a[gi*W +: W];
            assign b_arr[gi]  = io_req_b[gi*W +: W];
            assign op_arr[gi] = io_req_opcode[gi*2 +: 2];
        end
    endgenerate

    arb_state_t        state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [W-1:0]      a_reg, b_reg, res_reg;
    logic [1:0]        op_reg;
    logic [7:0]        ops_done_reg;
    logic [W-1:0]      alu_result;

    logic [ID_W-1:0]   winner;
    logic              req_found;

    // Search upward from rr_ptr with wrap; the first valid index wins.
    always_comb begin
        int idx;
        winner    = '0;
        req_found = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N;
            if (!req_found && io_req_valid[idx]) begin
                req_found = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        io_req_ready = '0;
        case (state_reg)
            IDLE: begin
                if (req_found) begin
                    io_req_ready = N'(1) << winner;
                    state_next   = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    if (io_resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            id_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            res_reg      <= '0;
            ops_done_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_found) begin
                        a_reg  <= a_arr[winner];
                        b_reg  <= b_arr[winner];
                        op_reg <= op_arr[winner];
                        id_reg <= winner;
                    end
                end
                EXEC: res_reg <= alu_result;
                RESP: begin
                    // Pointer moves only on a completed handshake so idle cycles never skip anyone.
                    if (io_resp_ready) begin
                        ops_done_reg <= ops_done_reg + 8'd1;
                        rr_ptr_reg   <= (id_reg == ID_W'(N - 1)) ? '0 : id_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    alu_share_arbiter_alu u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .opcode (op_reg),
        .result (alu_result)
    );

    assign io_resp_valid = (state_reg == RESP);
    assign io_resp_data  = res_reg;
    assign io_resp_id    = id_reg;
    assign io_busy       = (state_reg != IDLE);
    assign io_ops_done   = ops_done_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: grant order, latency, backpressure, opcodes, reset abort, counter wrap.
module tb_alu_share_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_opcode;
    logic        resp_valid;
    logic        resp_ready;
    logic [3:0]  resp_data;
    logic [1:0]  resp_id;
    logic        busy;
    logic [7:0]  ops_done;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_ops = 8'd0;

    alu_share_arbiter #(.N(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_req_valid  (req_valid),
        .io_req_ready  (req_ready),
        .io_req_a      (req_a),
        .io_req_b      (req_b),
        .io_req_opcode (req_opcode),
        .io_resp_valid (resp_valid),
        .io_resp_ready (resp_ready),
        .io_resp_data  (resp_data),
        .io_resp_id    (resp_id),
        .io_busy       (busy),
        .io_ops_done   (ops_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        req_a[i*4 +: 4]      = a;
        req_b[i*4 +: 4]      = b;
        req_opcode[i*2 +: 2] = op;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ops = 8'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        checks++; if (resp_data !== 4'd0) begin failures++; $display("FAIL reset_resp_data got=%0d want=0", resp_data); end
        checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_resp_id got=%0d want=0", resp_id); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (ops_done !== 8'd0) begin failures++; $display("FAIL reset_ops_done got=%0d want=0", ops_done); end
        reset = 1'b0;
        exp_ops = 8'd0;
        tick();
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_single();
        set_req(2, 4'd9, 4'd8, 2'b00);
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b want=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_exec valid=%b busy=%b want valid=0 busy=1", resp_valid, busy); end
        tick();
        checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL single_resp_valid got=%b want=1", resp_valid); end
        checks++; if (resp_data !== 4'd1) begin failures++; $display("FAIL single_data got=%0d want=1", resp_data); end
        checks++; if (resp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d want=2", resp_id); end
        tick();
        exp_ops = exp_ops + 8'd1;
        checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL single_ops_done got=%0d want=%0d", ops_done, exp_ops); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b want=0", busy); end
        $display("test_single done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_full_load();
        logic [3:0] want_grant;
        int want_id;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'd3, 4'd5, 2'b01);
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            want_id    = k % 4;
            want_grant = 4'b0001 << want_id;
            checks++; if (req_ready !== want_grant) begin failures++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, req_ready, want_grant); end
            tick();
            checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rr_exec_valid[%0d] got=%b want=0", k, resp_valid); end
            tick();
            checks++; if (resp_valid !== 1'b1 || resp_data !== 4'd14 || resp_id !== 2'(want_id)) begin
                failures++; $display("FAIL rr_resp[%0d] valid=%b data=%0d id=%0d want valid=1 data=14 id=%0d", k, resp_valid, resp_data, resp_id, want_id);
            end
            tick();
            exp_ops = exp_ops + 8'd1;
            checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL rr_ops_done[%0d] got=%0d want=%0d", k, ops_done, exp_ops); end
        end
        req_valid = 4'b0000;
        $display("test_full_load done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_backpressure();
        set_req(3, 4'd7, 4'd2, 2'b00);
        resp_ready = 1'b0;
        req_valid  = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL bp_grant got=%b want=1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        set_req(0, 4'd3, 4'd5, 2'b01);
        req_valid = 4'b0001;
        #1;
        for (int c = 0; c < 10; c++) begin
            checks++; if (resp_valid !== 1'b1 || resp_data !== 4'd9 || resp_id !== 2'd3 || req_ready !== 4'b0000 || ops_done !== exp_ops) begin
                failures++; $display("FAIL bp_hold[%0d] valid=%b data=%0d id=%0d ready=%b ops=%0d want 1/9/3/0000/%0d", c, resp_valid, resp_data, resp_id, req_ready, ops_done, exp_ops);
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        exp_ops = exp_ops + 8'd1;
        checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL bp_release_ops got=%0d want=%0d", ops_done, exp_ops); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_waiting_grant got=%b want=0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (resp_data !== 4'd14 || resp_id !== 2'd0) begin failures++; $display("FAIL bp_followup data=%0d id=%0d want 14/0", resp_data, resp_id); end
        tick();
        exp_ops = exp_ops + 8'd1;
        $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_pass();
        logic [3:0] want;
        for (int p = 0; p < 2; p++) begin
            set_req(1, 4'hA, 4'h5, (p == 0) ? 2'b10 : 2'b11);
            want = (p == 0) ? 4'hA : 4'h5;
            resp_ready = 1'b1;
            req_valid  = 4'b0010;
            #1;
            checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL pass_grant[%0d] got=%b want=0010", p, req_ready); end
            tick();
            req_valid = 4'b0000;
            tick();
            checks++; if (resp_data !== want || resp_id !== 2'd1) begin failures++; $display("FAIL pass_data[%0d] data=%h id=%0d want %h/1", p, resp_data, resp_id, want); end
            tick();
            exp_ops = exp_ops + 8'd1;
            checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL pass_ops[%0d] got=%0d want=%0d", p, ops_done, exp_ops); end
        end
        $display("test_pass done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_exec();
        set_req(3, 4'd1, 4'd1, 2'b00);
        resp_ready = 1'b1;
        req_valid  = 4'b1000;
        tick();
        req_valid = 4'b0000;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_exec_busy got=%b want=1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_ops = 8'd0;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || ops_done !== 8'd0) begin
            failures++; $display("FAIL rst_exec_state busy=%b valid=%b ops=%0d want 0/0/0", busy, resp_valid, ops_done);
        end
        req_valid = 4'b1100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rst_exec_next_grant got=%b want=0100", req_ready); end
        req_valid = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_exec_no_resp[%0d] got=%b want=0", c, resp_valid); end
        end
        $display("test_reset_exec done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_counter_wrap();
        do_reset();
        set_req(0, 4'd4, 4'd4, 2'b00);
        resp_ready = 1'b1;
        req_valid  = 4'b0001;
        for (int n = 1; n <= 256; n++) begin
            tick();
            tick();
            tick();
            exp_ops = exp_ops + 8'd1;
            if (n == 128 || n == 255 || n == 256) begin
                checks++; if (ops_done !== exp_ops) begin failures++; $display("FAIL wrap_ops[%0d] got=%0d want=%0d", n, ops_done, exp_ops); end
            end
        end
        req_valid = 4'b0000;
        checks++; if (ops_done !== 8'd0) begin failures++; $display("FAIL wrap_final got=%0d want=0", ops_done); end
        $display("test_counter_wrap done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 4'b0000;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single();
        test_full_load();
        test_backpressure();
        test_pass();
        test_reset_exec();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
